// File: rtl/bounds_checked_regfile.sv
// ============================================================================
//  Module   : bounds_checked_regfile
//  Brief    : Small register file with a power-up zeroing sweep, 1-cycle read
//             latency, out-of-bounds detection on both ports and an error
//             counter for dropped writes.
//  Options  : define BCRF_LAST_OOB_CAPTURE_EN to capture the address of the
//             most recent dropped write on o_last_oob_addr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounds_checked_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_oob,
  output logic [DEPTH-1:0]  o_vec,
  input  logic              i_err_clr,
  output logic [7:0]        o_err_count,
  output logic              o_err_sticky,
  output logic [ADDR_W-1:0] o_last_oob_addr
);

  // Index width just large enough to address every real entry.
  localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // The address ports must be able to reach every entry.
  generate
    if ((2 ** ADDR_W) < DEPTH) begin : g_addr_w_check
      $error("bounds_checked_regfile: 2**ADDR_W (%0d) < DEPTH (%0d)", 2 ** ADDR_W, DEPTH);
    end
    if ((DEPTH < 2) || (DEPTH > 256)) begin : g_depth_check
      $error("bounds_checked_regfile: DEPTH (%0d) outside 2..256", DEPTH);
    end
  endgenerate

  logic [0:0]         r_state;
  logic [C_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_oob;
  logic [7:0]         r_err_count;
  logic               r_err_sticky;

  logic               w_wr_accept;
  logic               w_wr_inb;
  logic               w_wr_store;
  logic               w_wr_drop;
  logic               w_rd_inb;
  logic [C_IDX_W-1:0] w_wr_idx;
  logic [C_IDX_W-1:0] w_rd_idx;

  // Address decode: bounds checks are done on the full-width address so that
  // aliasing addresses beyond DEPTH are never folded onto real entries.
  always_comb begin
    w_wr_accept = i_wr_valid && (r_state == S_RUN);
    w_wr_inb    = (32'(i_wr_addr) < 32'(DEPTH));
    w_rd_inb    = (32'(i_rd_addr) < 32'(DEPTH));
    w_wr_store  = w_wr_accept && w_wr_inb;
    w_wr_drop   = w_wr_accept && !w_wr_inb;
    w_wr_idx    = i_wr_addr[C_IDX_W-1:0];
    w_rd_idx    = i_rd_addr[C_IDX_W-1:0];
  end

  // Sequencer: sweep every entry to zero after reset, then accept writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else if (r_state == S_INIT) begin
      if (r_idx == C_IDX_W'(DEPTH - 1)) begin
        r_state <= S_RUN;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Storage: zeroing sweep during INIT, in-bounds accepted writes during RUN.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_INIT) begin
        r_mem[r_idx] <= '0;
      end else if (w_wr_store) begin
        r_mem[w_wr_idx] <= i_wr_data;
      end
    end
  end

  // Registered read; sampling pre-edge storage gives read-before-write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_rd_oob  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_inb ? r_mem[w_rd_idx] : '0;
      r_rd_oob  <= !w_rd_inb;
    end
  end

  // Dropped-write accounting; a clear coinciding with a drop counts that drop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_count  <= 8'd0;
      r_err_sticky <= 1'b0;
    end else if (i_err_clr) begin
      r_err_count  <= w_wr_drop ? 8'd1 : 8'd0;
      r_err_sticky <= w_wr_drop;
    end else if (w_wr_drop) begin
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
      r_err_sticky <= 1'b1;
    end
  end

`ifdef BCRF_LAST_OOB_CAPTURE_EN
  logic [ADDR_W-1:0] r_last_oob_addr;

  // Capture the address of each dropped write; the error clear leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_oob_addr <= '0;
    end else if (w_wr_drop) begin
      r_last_oob_addr <= i_wr_addr;
    end
  end

  assign o_last_oob_addr = r_last_oob_addr;
`else
  assign o_last_oob_addr = '0;
`endif

  // Bit 0 of each entry, straight from storage.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vec
      assign o_vec[gi] = r_mem[gi][0];
    end
  endgenerate

  assign o_wr_ready   = (r_state == S_RUN) && !i_rst;
  assign o_rd_data    = r_rd_data;
  assign o_rd_oob     = r_rd_oob;
  assign o_err_count  = r_err_count;
  assign o_err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_bounds_checked_regfile.sv
// ============================================================================
//  Module   : tb_bounds_checked_regfile
//  Brief    : Directed self-checking bench for bounds_checked_regfile
//             (DATA_W=8, DEPTH=4, ADDR_W=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bounds_checked_regfile;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_wr_valid;
  logic [3:0] i_wr_addr;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic [3:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       o_rd_oob;
  logic [3:0] o_vec;
  logic       i_err_clr;
  logic [7:0] o_err_count;
  logic       o_err_sticky;
  logic [3:0] o_last_oob_addr;

  int n_vec = 0;
  int n_err = 0;

  bounds_checked_regfile #(
    .DATA_W(8),
    .DEPTH (4),
    .ADDR_W(4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_wr_valid     (i_wr_valid),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .o_wr_ready     (o_wr_ready),
    .i_rd_addr      (i_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_rd_oob       (o_rd_oob),
    .o_vec          (o_vec),
    .i_err_clr      (i_err_clr),
    .o_err_count    (o_err_count),
    .o_err_sticky   (o_err_sticky),
    .o_last_oob_addr(o_last_oob_addr)
  );

  always #5 i_clk = ~i_clk;

  // Expected captured address depends on whether the capture option is built.
  function automatic logic [3:0] exp_last(input logic [3:0] a);
`ifdef BCRF_LAST_OOB_CAPTURE_EN
    return a;
`else
    return 4'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the 4-cycle INIT sweep: ready low for exactly 4 cycles, then high.
  task automatic check_init_sweep(input string tag);
    for (int c = 0; c < 4; c++) begin
      check({tag, "_ready_low"}, 32'(o_wr_ready), 32'd0);
      tick();
    end
    check({tag, "_ready_high"}, 32'(o_wr_ready), 32'd1);
  endtask

  task automatic read_expect(input string tag, input logic [3:0] a,
                             input logic [7:0] d, input logic oob);
    i_rd_addr = a;
    tick();
    check({tag, "_data"}, 32'(o_rd_data), 32'(d));
    check({tag, "_oob"}, 32'(o_rd_oob), 32'(oob));
  endtask

  initial begin
    i_rst      = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_addr  = 4'd0;
    i_wr_data  = 8'd0;
    i_rd_addr  = 4'd0;
    i_err_clr  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ready",  32'(o_wr_ready),      32'd0);
    check("rst_rdata",  32'(o_rd_data),       32'd0);
    check("rst_rdoob",  32'(o_rd_oob),        32'd0);
    check("rst_count",  32'(o_err_count),     32'd0);
    check("rst_sticky", 32'(o_err_sticky),    32'd0);
    check("rst_last",   32'(o_last_oob_addr), 32'd0);

    // Release reset with an out-of-bounds write held: it must be ignored in INIT
    i_rst      = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = 4'd9;
    i_wr_data  = 8'hFF;
    check_init_sweep("init");
    i_wr_valid = 1'b0;
    check("init_count",  32'(o_err_count),  32'd0);
    check("init_sticky", 32'(o_err_sticky), 32'd0);
    check("init_vec",    32'(o_vec),        32'd0);
    for (int a = 0; a < 4; a++) read_expect("init_rd", 4'(a), 8'h00, 1'b0);

    // In-bounds write and 1-cycle read
    i_wr_valid = 1'b1; i_wr_addr = 4'd2; i_wr_data = 8'hA5;
    tick();
    i_wr_valid = 1'b0;
    check("wr2_vec", 32'(o_vec), 32'h4);
    read_expect("wr2_rd", 4'd2, 8'hA5, 1'b0);

    // Dropped write to address 9
    i_wr_valid = 1'b1; i_wr_addr = 4'd9; i_wr_data = 8'hFF;
    tick();
    i_wr_valid = 1'b0;
    check("oob9_count",  32'(o_err_count),     32'd1);
    check("oob9_sticky", 32'(o_err_sticky),    32'd1);
    check("oob9_last",   32'(o_last_oob_addr), 32'(exp_last(4'd9)));
    check("oob9_vec",    32'(o_vec),           32'h4);
    read_expect("oob9_rd",  4'd9, 8'h00, 1'b1);
    read_expect("keep2_rd", 4'd2, 8'hA5, 1'b0);
    read_expect("keep1_rd", 4'd1, 8'h00, 1'b0);
    // Boundary of the address space: 4 is the first out-of-bounds read
    read_expect("bnd4_rd", 4'd4, 8'h00, 1'b1);
    read_expect("bnd3_rd", 4'd3, 8'h00, 1'b0);

    // Read-before-write on the same address
    i_wr_valid = 1'b1; i_wr_addr = 4'd1; i_wr_data = 8'h11;
    tick();
    check("wr1_vec", 32'(o_vec), 32'h6);
    i_wr_data = 8'h22; i_rd_addr = 4'd1;
    tick();
    i_wr_valid = 1'b0;
    check("rbw_old", 32'(o_rd_data), 32'h11);
    tick();
    check("rbw_new", 32'(o_rd_data), 32'h22);
    check("rbw_vec", 32'(o_vec),     32'h4);

    // Saturating error counter: starts at 1, 253 drops -> 254, 47 more -> 255
    i_wr_valid = 1'b1; i_wr_addr = 4'd4; i_wr_data = 8'h5A;
    for (int n = 0; n < 253; n++) tick();
    check("sat_254", 32'(o_err_count), 32'd254);
    for (int n = 0; n < 47; n++) tick();
    check("sat_255",    32'(o_err_count),     32'd255);
    check("sat_last",   32'(o_last_oob_addr), 32'(exp_last(4'd4)));
    check("sat_vec",    32'(o_vec),           32'h4);

    // Clear coinciding with a drop, then a plain clear
    i_wr_addr = 4'd15; i_err_clr = 1'b1;
    tick();
    i_wr_valid = 1'b0;
    check("clrw_count",  32'(o_err_count),  32'd1);
    check("clrw_sticky", 32'(o_err_sticky), 32'd1);
    tick();
    i_err_clr = 1'b0;
    check("clr_count",  32'(o_err_count),     32'd0);
    check("clr_sticky", 32'(o_err_sticky),    32'd0);
    check("clr_last",   32'(o_last_oob_addr), 32'(exp_last(4'd15)));

    // Fill entry 3 and 0 too, then reset in RUN
    i_wr_valid = 1'b1; i_wr_addr = 4'd3; i_wr_data = 8'h81;
    tick();
    i_wr_addr = 4'd0; i_wr_data = 8'h07;
    tick();
    i_wr_addr = 4'd8;
    tick();
    i_wr_valid = 1'b0;
    check("pre_vec",   32'(o_vec),       32'hD);
    check("pre_count", 32'(o_err_count), 32'd1);
    i_rst = 1'b1;
    tick();
    check("rrun_ready", 32'(o_wr_ready),      32'd0);
    check("rrun_count", 32'(o_err_count),     32'd0);
    check("rrun_last",  32'(o_last_oob_addr), 32'd0);
    i_rst = 1'b0;
    check_init_sweep("rrun");
    check("rrun_vec", 32'(o_vec), 32'd0);
    for (int a = 0; a < 4; a++) read_expect("rrun_rd", 4'(a), 8'h00, 1'b0);

    // Reset mid-INIT restarts the sweep from index 0
    i_wr_valid = 1'b1; i_wr_addr = 4'd2; i_wr_data = 8'h33;
    tick();
    i_wr_valid = 1'b0;
    check("mid_vec_pre", 32'(o_vec), 32'h4);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_init_sweep("minit");
    check("minit_vec", 32'(o_vec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bounds_checked_regfile.md
BOUNDS_CHECKED_REGFILE -- requirements
Module: bounds_checked_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 8: entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; legal range 2..256.
REQ-003 SHALL have parameter ADDR_W, default 4: address width; elaboration SHALL fail when 2**ADDR_W < DEPTH.
REQ-004 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_wr_valid, input, 1: write request.
REQ-007 SHALL have port i_wr_addr, input, ADDR_W: write address.
REQ-008 SHALL have port i_wr_data, input, DATA_W: write data.
REQ-009 SHALL have port o_wr_ready, output, 1: write port can accept.
REQ-010 SHALL have port i_rd_addr, input, ADDR_W: read address, sampled every cycle.
REQ-011 SHALL have port o_rd_data, output, DATA_W: registered read data.
REQ-012 SHALL have port o_rd_oob, output, 1: registered flag, last sampled read address was out of bounds.
REQ-013 SHALL have port o_vec, output, DEPTH: bit 0 of every entry, combinational from storage.
REQ-014 SHALL have port i_err_clr, input, 1: clear error counter and sticky flag.
REQ-015 SHALL have port o_err_count, output, 8: count of dropped out-of-bounds writes.
REQ-016 SHALL have port o_err_sticky, output, 1: at least one out-of-bounds write since last clear.
REQ-017 SHALL have port o_last_oob_addr, output, ADDR_W: address of the most recent dropped write.

Function
REQ-018 SHALL have a two-state FSM: INIT and RUN.
REQ-019 In INIT, an index counter SHALL zero one entry per cycle, from 0 to DEPTH-1, with o_wr_ready=0; after writing entry DEPTH-1 the FSM SHALL move to RUN on the next edge.
REQ-020 In RUN, o_wr_ready SHALL be 1.
REQ-021 A write SHALL be accepted only when i_wr_valid and o_wr_ready are both 1.
REQ-022 An accepted write with i_wr_addr < DEPTH SHALL update that entry at the same edge.
REQ-023 An accepted write with i_wr_addr >= DEPTH SHALL leave all storage unchanged, increment o_err_count (saturating at 255) and set o_err_sticky.
REQ-024 Requests with i_wr_valid=1 during INIT SHALL be ignored: no storage update and no error counting.
REQ-025 Read latency SHALL be 1 cycle: o_rd_data is the entry at the address sampled on the previous edge.
REQ-026 An out-of-bounds read SHALL return 0 with o_rd_oob=1.
REQ-027 A read and write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-028 i_err_clr SHALL zero the counter and the sticky flag; if it coincides with an out-of-bounds write, the result SHALL be count=1 and sticky=1.

Reset
REQ-029 i_rst=1 SHALL force FSM=INIT, index=0, o_rd_data=0, o_rd_oob=0, o_err_count=0, o_err_sticky=0 and o_last_oob_addr=0; o_wr_ready=0 throughout reset.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the INIT sweep from index 0.

Configuration
REQ-031 With BCRF_LAST_OOB_CAPTURE_EN defined, o_last_oob_addr SHALL load i_wr_addr on every dropped write and hold its value otherwise; it SHALL not be cleared by i_err_clr.
REQ-032 Without BCRF_LAST_OOB_CAPTURE_EN, o_last_oob_addr SHALL be constant 0 and no capture register SHALL exist.

Verification (DATA_W=8, DEPTH=4, ADDR_W=4)
REQ-033 Release reset, then hold i_wr_valid=1 -> o_wr_ready=0 for exactly 4 cycles, then 1; all entries read 0x00 and o_err_count=0.
REQ-034 Write addr 2, data 0xA5, then set i_rd_addr=2 -> o_rd_data=0xA5 one cycle later, o_vec=4'b0100.
REQ-035 Write addr 9, data 0xFF -> storage unchanged, o_err_count=1, o_err_sticky=1, o_last_oob_addr=9 (macro on) or 0 (macro off); reading addr 9 gives 0x00 with o_rd_oob=1.
REQ-036 Issue 300 out-of-bounds writes -> o_err_count=255; assert i_err_clr together with one more out-of-bounds write -> o_err_count=1.
REQ-037 Entry 1 holds 0x11; write 0x22 to addr 1 with i_rd_addr=1 in the same cycle -> next-cycle o_rd_data=0x11, and the following cycle 0x22.
REQ-038 Pulse i_rst in RUN with entries non-zero -> ready low for 4 cycles, all entries 0x00, counters 0.
